trdb_packet_packer: RTL and testbench
=====================================

TRDB_PACKET_PACKER -- requirements
Module: trdb_packet_packer

Interface
REQ-001 Parameter PKT_W, default 128, maximum trace packet width in bits.
REQ-002 Parameter WORD_W, default 32, output word width in bits; PKT_W SHALL be a multiple of WORD_W.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 packet_i  input  PKT_W  trace packet from the trace debugger, LSB-first payload.
REQ-006 packet_len_i  input  8  valid bit count of packet_i, 0..PKT_W.
REQ-007 packet_valid_i  input  1  packet offered.
REQ-008 packet_ready_o  output  1  packet accepted when valid and ready are both high.
REQ-009 flush_i  input  1  one-cycle request to drain residue as a zero-padded word.
REQ-010 word_o  output  WORD_W  packed output word.
REQ-011 word_valid_o  output  1  word offered downstream.
REQ-012 word_ready_i  input  1  downstream accepts word.
REQ-013 flush_done_o  output  1  one-cycle pulse when a flush completes.
REQ-014 fill_o  output  8  current number of buffered bits, status only.

Function
REQ-015 Internal buffer SHALL be PKT_W+WORD_W bits wide, with fill count range 0..PKT_W+WORD_W-1.
REQ-016 FSM states SHALL be IDLE (fill<WORD_W, accepting), EMIT (fill>=WORD_W, outputting), FLUSH (emit padded residue).
REQ-017 packet_ready_o SHALL be high only in IDLE with flush_pending low; it SHALL be registered-state-derived, with no combinational path from flush_i.
REQ-018 On accept: bits of packet_i at or above packet_len_i SHALL be masked to 0; buf SHALL become buf | (masked << fill); fill SHALL become fill+len.
REQ-019 On accept, the FSM SHALL go to EMIT if fill+len>=WORD_W, else stay IDLE; len=0 is accepted with no state change.
REQ-020 packet_len_i>PKT_W SHALL be treated as PKT_W.
REQ-021 In EMIT: word_o=buf[WORD_W-1:0], word_valid_o=1; on word_ready_i, buf SHALL shift right WORD_W with zero fill, and fill SHALL be decremented by WORD_W.
REQ-022 After a word handshake in EMIT: if the new fill<WORD_W, go to IDLE, else stay in EMIT.
REQ-023 word_o and word_valid_o SHALL remain stable while word_valid_o=1 and word_ready_i=0.
REQ-024 The first output word SHALL be valid the cycle after the accepting edge; zero-stall throughput is one word per cycle.
REQ-025 flush_i SHALL set flush_pending in any state; flush_pending SHALL be acted on only in IDLE.
REQ-026 IDLE with flush_pending and fill>0: go to FLUSH; word_o=buf[WORD_W-1:0] with bits >=fill zero; on handshake, fill<=0, buf<=0, flush_pending<=0, pulse flush_done_o, go to IDLE.
REQ-027 IDLE with flush_pending and fill=0: clear flush_pending and pulse flush_done_o next cycle; no word is emitted.
REQ-028 A packet and flush_i in the same IDLE cycle: the packet SHALL be accepted first, and the flush SHALL apply after its full words drain.
REQ-029 flush_i while flush_pending is already set SHALL be merged and produce one flush_done_o.

Reset
REQ-030 On rst_ni low: state=IDLE, buf=0, fill=0, flush_pending=0; word_valid_o=0, word_o=0, flush_done_o=0, fill_o=0, packet_ready_o=0 during reset.
REQ-031 Reset mid-EMIT or mid-FLUSH SHALL discard all buffered bits with no further word output; packet_ready_o SHALL go high in the first cycle after release.

Structure
REQ-032 Package trdb_pkg SHALL hold PKT_W/WORD_W defaults, the state enum (IDLE, EMIT, FLUSH), and the fill counter width.
REQ-033 The block SHALL be a single module with no sub-modules; the masking shifter is inline logic.

Verification
REQ-034 Accept len=40 with packet 0xAB_DEADBEEF, ready=1 -> word 0xDEADBEEF the next cycle, then IDLE with fill=8.
REQ-035 Then len=24 with packet 0x123456 -> word 0x123456AB, fill=0.
REQ-036 len=128 with 0x0123..CDEF, fill=0, word_ready_i low for 5 cycles -> word stable and packet_ready_o=0; after release, 4 consecutive words in LSB order.
REQ-037 fill=8, buf=0xAB, flush_i pulse -> word 0x000000AB, then a flush_done_o pulse, fill=0; flush at fill=0 -> flush_done_o only, no word.
REQ-038 Packet len=20 with bits above 20 all ones -> the emitted/flushed word has bits [31:20]=0.
REQ-039 rst_ni asserted in EMIT with fill=96 -> outputs zero immediately; after release, no stale word and packet_ready_o=1.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared sizing and FSM encoding for the trace packet packer.
package trdb_pkg;

  localparam int PKT_W_DEF  = 128;
  localparam int WORD_W_DEF = 32;
  localparam int FILL_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/trdb_packet_packer.sv
// Packs variable-length trace packets LSB-first into WORD_W words; first word one cycle after accept.
// Packets stall while a word or a flush is pending; words hold steady under word_ready_i low.
module trdb_packet_packer
  import trdb_pkg::*;
#(
  parameter int PKT_W  = PKT_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PKT_W-1:0]  packet_i,
  input  logic [7:0]        packet_len_i,
  input  logic              packet_valid_i,
  output logic              packet_ready_o,
  input  logic              flush_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              flush_done_o,
  output logic [7:0]        fill_o
);

  localparam int                BUF_W   = PKT_W + WORD_W;
  localparam logic [FILL_W-1:0] WORD_F  = FILL_W'(WORD_W);
  localparam logic [7:0]        PKT_LEN = 8'(PKT_W);

  state_e            state_q, state_d;
  logic [BUF_W-1:0]  buf_q;
  logic [FILL_W-1:0] fill_q;
  logic              flush_pend_q, flush_pend_d;
  logic              ready_q;
  logic              done_q;
  logic              flush_clr;

  logic              accept;
  logic              word_hs;
  logic [7:0]        len_eff;
  logic [BUF_W-1:0]  pkt_masked;
  logic [FILL_W-1:0] fill_acc;
  logic [FILL_W-1:0] fill_sub;

  assign accept     = packet_valid_i && ready_q;
  assign word_hs    = word_valid_o && word_ready_i;
  assign len_eff    = (packet_len_i > PKT_LEN) ? PKT_LEN : packet_len_i;
  assign pkt_masked = {{WORD_W{1'b0}}, packet_i} & ~({BUF_W{1'b1}} << len_eff);
  assign fill_acc   = fill_q + FILL_W'(len_eff);
  assign fill_sub   = fill_q - WORD_F;

  // A flush retires either immediately (nothing buffered) or on the padded word's handshake.
  assign flush_clr    = ((state_q == IDLE) && flush_pend_q && (fill_q == '0)) ||
                        ((state_q == FLUSH) && word_hs);
  assign flush_pend_d = (flush_pend_q | flush_i) & ~flush_clr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fill_acc >= WORD_F) state_d = EMIT;
        end else if (flush_pend_q && (fill_q != '0)) begin
          state_d = FLUSH;
        end
      end
      EMIT:    if (word_hs && (fill_sub < WORD_F)) state_d = IDLE;
      FLUSH:   if (word_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_valid_o = 1'b0;
    word_o       = '0;
    case (state_q)
      EMIT: begin
        word_valid_o = 1'b1;
        word_o       = buf_q[WORD_W-1:0];
      end
      FLUSH: begin
        word_valid_o = 1'b1;
        word_o       = buf_q[WORD_W-1:0] & ~({WORD_W{1'b1}} << fill_q);
      end
      default: ;
    endcase
  end

  // Ready is registered from the next state so flush_i never reaches packet_ready_o combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
      ready_q      <= (state_d == IDLE) && !flush_pend_d;
      done_q       <= flush_clr;
      if (state_q == IDLE && accept) begin
        buf_q  <= buf_q | (pkt_masked << fill_q);
        fill_q <= fill_acc;
      end else if (state_q == EMIT && word_hs) begin
        buf_q  <= buf_q >> WORD_W;
        fill_q <= fill_sub;
      end else if (state_q == FLUSH && word_hs) begin
        buf_q  <= '0;
        fill_q <= '0;
      end
    end
  end

  assign packet_ready_o = ready_q;
  assign flush_done_o   = done_q;
  assign fill_o         = 8'(fill_q);

endmodule

// File: tb/tb_trdb_packet_packer.sv
// Directed bench for trdb_packet_packer: hand-computed words, fill levels and flush pulses.
module tb_trdb_packet_packer;

  logic         clk;
  logic         rst_ni;
  logic [127:0] packet_i;
  logic [7:0]   packet_len_i;
  logic         packet_valid_i;
  logic         packet_ready_o;
  logic         flush_i;
  logic [31:0]  word_o;
  logic         word_valid_o;
  logic         word_ready_i;
  logic         flush_done_o;
  logic [7:0]   fill_o;

  int tests  = 0;
  int failed = 0;

  trdb_packet_packer dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .packet_i       (packet_i),
    .packet_len_i   (packet_len_i),
    .packet_valid_i (packet_valid_i),
    .packet_ready_o (packet_ready_o),
    .flush_i        (flush_i),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .flush_done_o   (flush_done_o),
    .fill_o         (fill_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] big;
    logic [31:0]  exp_w [4];
    logic [127:0] p;
    int           pulses;
    int           words;

    rst_ni = 1'b0; packet_i = '0; packet_len_i = '0; packet_valid_i = 1'b0;
    flush_i = 1'b0; word_ready_i = 1'b1;
    #2;
    chk("rst_ready", packet_ready_o, 1'b0);
    chk("rst_wvld",  word_valid_o, 1'b0);
    chk("rst_word",  word_o, 32'h0);
    chk("rst_done",  flush_done_o, 1'b0);
    chk("rst_fill",  fill_o, 8'd0);
    tick; tick;
    rst_ni = 1'b1;
    tick;
    chk("post_rst_ready", packet_ready_o, 1'b1);

    // 40-bit packet: one full word then 8 residue bits
    packet_i = 128'hAB_DEADBEEF; packet_len_i = 8'd40; packet_valid_i = 1'b1;
    tick;
    packet_valid_i = 1'b0;
    chk("p40_wvld", word_valid_o, 1'b1);
    chk("p40_word", word_o, 32'hDEADBEEF);
    chk("p40_fill", fill_o, 8'd40);
    tick;
    chk("p40_idle_wvld", word_valid_o, 1'b0);
    chk("p40_idle_fill", fill_o, 8'd8);
    chk("p40_idle_rdy",  packet_ready_o, 1'b1);

    packet_i = 128'h123456; packet_len_i = 8'd24; packet_valid_i = 1'b1;
    tick;
    packet_valid_i = 1'b0;
    chk("p24_word", word_o, 32'h123456AB);
    chk("p24_wvld", word_valid_o, 1'b1);
    tick;
    chk("p24_fill", fill_o, 8'd0);
    chk("p24_wvld_off", word_valid_o, 1'b0);

    // Full-width packet under 5 cycles of downstream stall
    big = 128'h01234567_76543210_FEDCBA98_89ABCDEF;
    exp_w[0] = 32'h89ABCDEF; exp_w[1] = 32'hFEDCBA98;
    exp_w[2] = 32'h76543210; exp_w[3] = 32'h01234567;
    word_ready_i = 1'b0;
    packet_i = big; packet_len_i = 8'd128; packet_valid_i = 1'b1;
    tick;
    packet_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_word", word_o, exp_w[0]);
      chk("stall_wvld", word_valid_o, 1'b1);
      chk("stall_rdy",  packet_ready_o, 1'b0);
      tick;
    end
    chk("stall_fill", fill_o, 8'd128);
    word_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_wvld", word_valid_o, 1'b1);
      chk("drain_word", word_o, exp_w[i]);
      tick;
    end
    chk("drain_done_wvld", word_valid_o, 1'b0);
    chk("drain_done_fill", fill_o, 8'd0);
    chk("drain_done_rdy",  packet_ready_o, 1'b1);

    // Flush of 8 residue bits
    packet_i = 128'hAB; packet_len_i = 8'd8; packet_valid_i = 1'b1;
    tick;
    packet_valid_i = 1'b0;
    chk("fl8_fill", fill_o, 8'd8);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("fl8_rdy_low", packet_ready_o, 1'b0);
    chk("fl8_no_word_yet", word_valid_o, 1'b0);
    tick;
    chk("fl8_wvld", word_valid_o, 1'b1);
    chk("fl8_word", word_o, 32'h000000AB);
    tick;
    chk("fl8_done", flush_done_o, 1'b1);
    chk("fl8_fill0", fill_o, 8'd0);
    chk("fl8_wvld_off", word_valid_o, 1'b0);
    tick;
    chk("fl8_done_pulse", flush_done_o, 1'b0);
    chk("fl8_rdy_back", packet_ready_o, 1'b1);

    // Flush with nothing buffered, flush_i held two cycles: merged into one pulse, no word
    pulses = 0; words = 0;
    flush_i = 1'b1;
    tick; pulses += int'(flush_done_o); words += int'(word_valid_o);
    tick; pulses += int'(flush_done_o); words += int'(word_valid_o);
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick; pulses += int'(flush_done_o); words += int'(word_valid_o);
    end
    chk("fl0_pulses", pulses, 1);
    chk("fl0_words",  words, 0);
    chk("fl0_rdy",    packet_ready_o, 1'b1);

    // Length masking: ones above the valid length must not leak
    p = '1; p[19:0] = 20'hABCDE;
    packet_i = p; packet_len_i = 8'd20; packet_valid_i = 1'b1;
    tick;
    p = '1; p[11:0] = 12'h345;
    packet_i = p; packet_len_i = 8'd12;
    tick;
    packet_valid_i = 1'b0;
    chk("mask_emit_word", word_o, 32'h345ABCDE);
    tick;
    chk("mask_emit_fill", fill_o, 8'd0);

    // Packet and flush in the same cycle: packet accepted, then padded residue
    p = '1; p[19:0] = 20'hABCDE;
    packet_i = p; packet_len_i = 8'd20; packet_valid_i = 1'b1; flush_i = 1'b1;
    tick;
    packet_valid_i = 1'b0; flush_i = 1'b0;
    chk("mask_fl_fill", fill_o, 8'd20);
    chk("mask_fl_rdy",  packet_ready_o, 1'b0);
    tick;
    chk("mask_fl_wvld", word_valid_o, 1'b1);
    chk("mask_fl_word", word_o, 32'h000ABCDE);
    tick;
    chk("mask_fl_done", flush_done_o, 1'b1);
    chk("mask_fl_fill0", fill_o, 8'd0);

    // Same-cycle flush behind a multi-word packet: full words first
    packet_i = 128'hAB_DEADBEEF; packet_len_i = 8'd40; packet_valid_i = 1'b1; flush_i = 1'b1;
    tick;
    packet_valid_i = 1'b0; flush_i = 1'b0;
    chk("pf_word0", word_o, 32'hDEADBEEF);
    tick;
    chk("pf_idle_wvld", word_valid_o, 1'b0);
    chk("pf_idle_fill", fill_o, 8'd8);
    tick;
    chk("pf_flush_word", word_o, 32'h000000AB);
    chk("pf_flush_wvld", word_valid_o, 1'b1);
    chk("pf_no_done_yet", flush_done_o, 1'b0);
    tick;
    chk("pf_done", flush_done_o, 1'b1);
    tick;

    // Over-range length is clamped to the packet width
    packet_i = 128'h11111111_22222222_33333333_44444444;
    packet_len_i = 8'd200; packet_valid_i = 1'b1;
    tick;
    packet_valid_i = 1'b0;
    chk("clamp_fill", fill_o, 8'd128);
    chk("clamp_word", word_o, 32'h44444444);
    tick; tick; tick;
    chk("clamp_last", word_o, 32'h11111111);
    tick;
    chk("clamp_fill0", fill_o, 8'd0);

    // Reset in EMIT with 96 bits buffered
    word_ready_i = 1'b0;
    packet_i = 128'h0; packet_i[95:0] = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
    packet_len_i = 8'd96; packet_valid_i = 1'b1;
    tick;
    packet_valid_i = 1'b0;
    chk("mid_fill", fill_o, 8'd96);
    chk("mid_wvld", word_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_wvld", word_valid_o, 1'b0);
    chk("mid_rst_word", word_o, 32'h0);
    chk("mid_rst_fill", fill_o, 8'd0);
    chk("mid_rst_rdy",  packet_ready_o, 1'b0);
    tick;
    rst_ni = 1'b1; word_ready_i = 1'b1;
    tick;
    chk("after_rst_rdy",  packet_ready_o, 1'b1);
    chk("after_rst_wvld", word_valid_o, 1'b0);
    tick;
    chk("after_rst_wvld2", word_valid_o, 1'b0);
    chk("after_rst_fill",  fill_o, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
